// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; MTHI/MTLO write in one cycle.
module mul_div_unit #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        neg_q, neg_d;
   logic        neg_rem_q, neg_rem_d;
   logic [31:0] opnd_q, opnd_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        signed_op;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum;
   logic [32:0] div_trial;
   logic [63:0] prod_fixed;
   logic [31:0] quot_fixed, rem_fixed;

   always_comb begin
      signed_op  = ~op[0];
      mag_a      = (signed_op && a[31]) ? (~a + 32'd1) : a;
      mag_b      = (signed_op && b[31]) ? (~b + 32'd1) : b;
      mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
      div_trial  = acc_q[63:31] - {1'b0, opnd_q};
      prod_fixed = neg_q ? (~acc_q + 64'd1) : acc_q;
      quot_fixed = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
      rem_fixed  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start && !cancel) begin
               unique case (op)
                  3'd0, 3'd1, 3'd2, 3'd3: begin
                     state_d   = S_RUN;
                     cnt_d     = '0;
                     is_div_d  = op[1];
                     // A zero divisor keeps the quotient positive so it stays all-ones
                     // and the signed remainder reconstructs the original dividend.
                     neg_d     = signed_op && (a[31] ^ b[31]) && (!op[1] || (b != '0));
                     neg_rem_d = signed_op && op[1] && a[31];
                     opnd_d    = op[1] ? mag_b : mag_a;
                     acc_d     = op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
                  end
                  3'd4: hi_d = a;
                  3'd5: lo_d = a;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               if (is_div_q) begin
                  if (!div_trial[32]) begin
                     acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
                  end else begin
                     acc_d = {acc_q[62:0], 1'b0};
                  end
               end else begin
                  acc_d = {mul_sum, acc_q[31:1]};
               end
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == LAST_ITER) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!cancel) begin
               if (is_div_q) begin
                  hi_d = rem_fixed;
                  lo_d = quot_fixed;
               end else begin
                  hi_d = prod_fixed[63:32];
                  lo_d = prod_fixed[31:0];
               end
               done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic results, latency,
// busy/cancel/reset behaviour and MTHI/MTLO.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   mul_div_unit #(.ITER(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Counts busy cycles after acceptance; returns with the done cycle visible.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 60) begin
         n++;
         tick();
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      start = 1'b1; op = o; a = av; b = bv;
      tick();
      start = 1'b0;
      wait_idle(n);
      check({tag, "_busy_cycles"}, 64'(n), 64'd33);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
      tick();
      check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
   endtask

   initial begin
      int n;
      int done_seen;
      rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; cancel = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_hi", 64'(hi), 64'd0);
      check("reset_lo", 64'(lo), 64'd0);

      run_op("mult_neg3x7", 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult_neg_neg", 3'd0, 32'hFFFFFFFE, 32'hFFFFFFFB, 32'h00000000, 32'h0000000A);
      run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("div_neg7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_7_neg2", 3'd2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      run_op("div_minint_neg1", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      run_op("divu_by_zero", 3'd3, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
      run_op("div_neg_by_zero", 3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

      // start while busy: the second request must be ignored
      start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("busy_hold_hi", 64'(hi), 64'hFFFFFFFB);
      check("busy_hold_lo", 64'(lo), 64'hFFFFFFFF);
      start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd3;
      tick();
      start = 1'b0;
      wait_idle(n);
      check("ignore_start_busy_cycles", 64'(n + 5), 64'd33);
      check("ignore_start_done", 64'(done), 64'd1);
      check("ignore_start_hi", 64'(hi), 64'd0);
      check("ignore_start_lo", 64'(lo), 64'd12);
      tick();

      // cancel mid-run
      start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd5;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("cancel_busy_before", 64'(busy), 64'd1);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check("cancel_busy_after", 64'(busy), 64'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) done_seen++;
         tick();
      end
      check("cancel_no_done", 64'(done_seen), 64'd0);
      check("cancel_hi", 64'(hi), 64'd0);
      check("cancel_lo", 64'(lo), 64'd12);

      // MTHI / MTLO
      start = 1'b1; op = 3'd4; a = 32'hA5A5A5A5;
      tick();
      start = 1'b0;
      check("mthi_hi", 64'(hi), 64'hA5A5A5A5);
      check("mthi_busy", 64'(busy), 64'd0);
      check("mthi_done", 64'(done), 64'd0);
      check("mthi_lo_kept", 64'(lo), 64'd12);
      start = 1'b1; op = 3'd5; a = 32'hDEADBEEF; cancel = 1'b1;
      tick();
      start = 1'b0; cancel = 1'b0;
      check("mtlo_cancel_lo", 64'(lo), 64'd12);
      start = 1'b1; op = 3'd5; a = 32'h00000055;
      tick();
      start = 1'b0;
      check("mtlo_lo", 64'(lo), 64'h55);
      check("mtlo_busy", 64'(busy), 64'd0);
      start = 1'b1; op = 3'd6; a = 32'h11111111; b = 32'h22222222;
      tick();
      start = 1'b0;
      check("nop_busy", 64'(busy), 64'd0);
      check("nop_hi", 64'(hi), 64'hA5A5A5A5);
      check("nop_lo", 64'(lo), 64'h55);

      // reset mid-operation
      start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
      tick();
      start = 1'b0;
      for (int i = 0; i < 19; i++) tick();
      check("rst_mid_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_hi", 64'(hi), 64'd0);
      check("rst_mid_lo", 64'(lo), 64'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) done_seen++;
         tick();
      end
      check("rst_mid_no_done", 64'(done_seen), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits directly downstream of the register file: its operands `a`/`b` come straight from the register file's two read ports (rs, rt). It executes MULT/MULTU/DIV/DIVU iteratively and handles MTHI/MTLO. HI/LO feed the MFHI/MFLO path back to register-file write-back, and `busy` stalls the pipeline.

## Interface
- `ITER`, 32, number of iteration cycles; fixed at 32 for 32-bit operands and not intended to be changed.
- `clk` input 1, single clock; all state updates on rising edge.
- `rst` input 1, synchronous, active-high reset, sampled on rising edge of `clk`.
- `start` input 1, request; sampled only when `busy`=0.
- `op` input 3, 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- `a` input 32, rs operand (register file read port 1): multiplicand/dividend, or MTHI/MTLO source.
- `b` input 32, rt operand (register file read port 2): multiplier/divisor.
- `cancel` input 1, pipeline flush; aborts an in-flight operation.
- `busy` output 1, operation in flight; the pipeline stalls any mul/div/MFHI/MFLO while it is high.
- `done` output 1, one-cycle pulse: HI/LO were just updated by a MULT/DIV-class op.
- `hi` output 32, HI register.
- `lo` output 32, LO register.

## Operation
- State machine: IDLE, RUN, FIX.
- **IDLE**
  - `start`=1 with op 0–3 → RUN.
    - Latch operand magnitudes (`|a|`, `|b|` for signed ops; raw values for unsigned ops), the result sign(s), and the op.
    - Clear the 5-bit iteration counter.
  - `start`=1 with op 4 → `hi`<=`a` at that edge; stay IDLE; no `busy`, no `done`.
  - `start`=1 with op 5 → `lo`<=`a` at that edge; stay IDLE; no `busy`, no `done`.
  - op 6/7 → no effect.
- **RUN**: one iteration per cycle; after the iteration with counter=31 → FIX.
  - Multiply: unsigned shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division with a 64-bit {remainder, quotient} shift register, one quotient bit per cycle, MSB first.
- **FIX**: apply sign correction, write `hi`/`lo`, pulse `done`, → IDLE.
  - MULT: 64-bit product negated if operand signs differ; `hi`=product[63:32], `lo`=product[31:0].
  - DIV: quotient negated if operand signs differ; remainder takes the dividend's sign; `lo`=quotient, `hi`=remainder.
  - MULTU/DIVU: no correction.
- **Divide by zero** (`b`=0, DIV or DIVU): runs full latency; result `lo`=32'hFFFFFFFF, `hi`=`a` (original value). It never raises an exception.
- **DIV 32'h80000000 / 32'hFFFFFFFF**: `lo`=32'h80000000 (wrap), `hi`=0.
- **`start` while `busy`=1**: ignored entirely; operands and op are not re-latched.
- **`cancel`**:
  - In RUN or FIX: → IDLE at that edge; `hi`/`lo` unchanged; no `done`.
  - In IDLE: overrides a same-cycle `start`, so nothing is accepted and MTHI/MTLO do not write.
- **`rst`**: has priority over everything, including mid-operation. → IDLE; `hi`=`lo`=0; `busy`=0; `done`=0; counter=0.

## Timing
- **Accept edge E**: `start`=1, `busy`=0, `cancel`=0, op 0–3.
- `busy`=1 in the cycles after edges E through E+32 (33 cycles).
- Iterations occur on edges E+1 … E+32.
- FIX writes `hi`/`lo` at edge E+33.
  - In the cycle after E+33: `busy`=0, `done`=1 (exactly one cycle), new `hi`/`lo` visible.
- A new `start` may be sampled at edge E+34 at the earliest, which is the first edge where `busy`=0 is seen.
- MTHI/MTLO: new value visible in the cycle after the accept edge; latency 1 cycle.
- `hi`/`lo` are registered outputs and hold their old values for the whole of an in-flight operation.
- `busy` and `done` are decoded from registered state only; there is no combinational path from inputs.

## Test plan
- **Signed multiply**: reset, then MULT `a`=32'hFFFFFFFD (−3), `b`=7 → `busy` high 33 cycles; `done` pulse; `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFEB.
- **Unsigned multiply**: MULTU `a`=32'hFFFFFFFF, `b`=32'hFFFFFFFF → `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
- **Unsigned and signed divide**:
  - DIVU 100/7 → `lo`=14, `hi`=2.
  - DIV −7/2 → `lo`=32'hFFFFFFFD, `hi`=32'hFFFFFFFF.
  - DIV 32'h80000000/32'hFFFFFFFF → `lo`=32'h80000000, `hi`=0.
- **Divide by zero**: DIVU `a`=32'h1234, `b`=0 → after 33 cycles, `lo`=32'hFFFFFFFF, `hi`=32'h1234, `done` pulses once.
- **Busy and cancel**:
  - `start` MULT 3×4, then re-assert `start` DIVU 9/3 at cycle 5 → second request ignored; result `lo`=12, `hi`=0.
  - Then start DIV and assert `cancel` at cycle 10 → `busy` drops next cycle, no `done`, `hi`/`lo` still 0/12.
- **MTHI/MTLO and reset**:
  - MTHI `a`=32'hA5A5A5A5 → `hi` updated one cycle later, `busy` never asserts.
  - MTLO with `cancel`=1 → `lo` unchanged.
  - Start MULT, assert `rst` at cycle 20 → `busy`=0, `hi`=`lo`=0, no `done`.
